// File: rtl/demux4_dispatch_controller_if.sv
// Handshake/bus bundle between the producer, the dispatch controller and the
// four demux consumers. Member names match the original controller ports.
interface demux4_dispatch_controller_if #(
    parameter int unsigned BITS  = 4,
    parameter int unsigned CNT_W = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [BITS-1:0]  IN_DATA;
    logic [1:0]       IN_DEST;
    logic             IN_RR;
    logic [1:0]       OUT_SELECT;
    logic [BITS-1:0]  OUT_DATA;
    logic [3:0]       OUT_VALID;
    logic [3:0]       OUT_READY;
    logic             BUSY;
    logic             TIMEOUT_ERR;
    logic [CNT_W-1:0] DROP_COUNT;

    // Environment side: producer and consumers
    modport master (
        output IN_VALID, IN_DATA, IN_DEST, IN_RR, OUT_READY,
        input  IN_READY, OUT_SELECT, OUT_DATA, OUT_VALID, BUSY, TIMEOUT_ERR, DROP_COUNT
    );

    // Controller side
    modport slave (
        input  IN_VALID, IN_DATA, IN_DEST, IN_RR, OUT_READY,
        output IN_READY, OUT_SELECT, OUT_DATA, OUT_VALID, BUSY, TIMEOUT_ERR, DROP_COUNT
    );
endinterface

// File: rtl/demux4_dispatch_controller.sv
// Dispatch controller for a 2-bit-select, four-output demultiplexer.
// Takes one word per handshake, routes it by tag or round-robin pointer,
// holds SELECT/DATA until the chosen consumer acknowledges, and drops items
// that stall longer than TIMEOUT cycles.
module demux4_dispatch_controller #(
    parameter int unsigned BITS    = 4,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic CLK,
    input  logic RST_N,
    demux4_dispatch_controller_if.slave bus
);

    // Counter only needs to reach TIMEOUT-1: the drop decision is made on the
    // stall cycle that would bring it to TIMEOUT.
    localparam int unsigned STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [BITS-1:0]    r_data;
    logic [3:0]         r_valid;
    logic               r_busy;
    logic               r_terr;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [1:0]         r_rr_ptr;
    logic               r_item_rr;
    logic [STALL_W-1:0] r_stall;

    logic [1:0]         w_dest;
    logic [3:0]         w_dest_onehot;
    logic               w_timeout_hit;

    // Destination chosen at the IN handshake and the stall-limit detector
    always_comb begin
        w_dest        = bus.IN_RR ? r_rr_ptr : bus.IN_DEST;
        w_dest_onehot = 4'b0001 << w_dest;
        w_timeout_hit = (TIMEOUT != 0) && (r_stall == STALL_LAST);
    end

    // Dispatch FSM with all outputs registered
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_data     <= '0;
            r_valid    <= '0;
            r_busy     <= 1'b0;
            r_terr     <= 1'b0;
            r_drop_cnt <= '0;
            r_rr_ptr   <= '0;
            r_item_rr  <= 1'b0;
            r_stall    <= '0;
        end else begin
            r_terr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.IN_VALID) begin
                        r_data    <= bus.IN_DATA;
                        r_sel     <= w_dest;
                        r_valid   <= w_dest_onehot;
                        r_item_rr <= bus.IN_RR;
                        r_stall   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Delivery is checked first so ready wins over a coincident timeout
                    if (bus.OUT_READY[r_sel]) begin
                        r_valid <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                        if (r_item_rr) begin
                            r_rr_ptr <= r_rr_ptr + 2'd1;
                        end
                    end else if (w_timeout_hit) begin
                        r_valid <= '0;
                        r_busy  <= 1'b0;
                        r_terr  <= 1'b1;
                        r_state <= ST_IDLE;
                        if (r_drop_cnt != '1) begin
                            r_drop_cnt <= r_drop_cnt + 1'b1;
                        end
                        if (r_item_rr) begin
                            r_rr_ptr <= r_rr_ptr + 2'd1;
                        end
                    end else if (TIMEOUT != 0) begin
                        r_stall <= r_stall + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.IN_READY    = (r_state == ST_IDLE);
    assign bus.OUT_SELECT  = r_sel;
    assign bus.OUT_DATA    = r_data;
    assign bus.OUT_VALID   = r_valid;
    assign bus.BUSY        = r_busy;
    assign bus.TIMEOUT_ERR = r_terr;
    assign bus.DROP_COUNT  = r_drop_cnt;

endmodule

// File: doc/demux4_dispatch_controller.md
Name: demux4_dispatch_controller

Overview:
- Sequences the 2-bit-select, four-output N-bit demultiplexer.
- Accepts one data word per handshake from a single producer and chooses the destination: either an explicit tag or a round-robin pointer.
- Drives the demux SELECT and DATA inputs and holds them stable until the chosen consumer (A/B/C/D) acknowledges.
- A per-item timeout drops words that stall on an unresponsive consumer and reports the drop.

Parameters:
- BITS, 4, data word width; matches the demux BITS.
- TIMEOUT, 15, maximum stall cycles in SEND before the item is dropped; 0 disables the timeout.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  producer has a word.
- IN_READY  output  1  controller can accept a word.
- IN_DATA  input  BITS  word to dispatch.
- IN_DEST  input  2  destination tag: 0=A, 1=B, 2=C, 3=D.
- IN_RR  input  1  1 = ignore IN_DEST and use the round-robin pointer.
- OUT_SELECT  output  2  to demux SELECT.
- OUT_DATA  output  BITS  to demux DATA.
- OUT_VALID  output  4  one-hot valid; bit k pairs with demux output k (0=A … 3=D).
- OUT_READY  input  4  per-consumer acknowledge.
- BUSY  output  1  item held in SEND.
- TIMEOUT_ERR  output  1  one-cycle pulse when an item is dropped.
- DROP_COUNT  output  CNT_W  saturating count of dropped items.

Behaviour:
- Reset (RST_N low, asynchronous) values:
  - state=IDLE, IN_READY=1 (combinational from state)
  - OUT_SELECT=0, OUT_DATA=0, OUT_VALID=0
  - BUSY=0, TIMEOUT_ERR=0, DROP_COUNT=0
  - rr_ptr=0, stall counter=0
- Reset mid-SEND abandons the held item silently: no TIMEOUT_ERR, no count.
- IDLE state:
  - IN_READY=1, OUT_VALID=0.
  - On IN_VALID=1 (transfer): register IN_DATA into OUT_DATA; dest = IN_RR ? rr_ptr : IN_DEST; register dest into OUT_SELECT; clear stall counter; go to SEND.
- SEND state:
  - IN_READY=0, BUSY=1, OUT_VALID = one-hot(OUT_SELECT).
  - OUT_SELECT and OUT_DATA are stable for the whole state.
  - If OUT_READY[OUT_SELECT]=1: item delivered; go to IDLE. If the item was round-robin, rr_ptr increments mod 4 (3 wraps to 0).
  - Only OUT_READY for the selected consumer matters; ready on other bits is ignored.
  - Otherwise: stall counter +1. If TIMEOUT≠0 and the counter reaches TIMEOUT, drop: pulse TIMEOUT_ERR for one cycle, increment DROP_COUNT (saturating at 2^CNT_W−1), advance rr_ptr if the item was round-robin, go to IDLE.
  - Ready and timeout in the same cycle: delivery wins, no error.
- Latency:
  - IN handshake to OUT_VALID is 1 cycle.
  - OUT handshake to IN_READY is 1 cycle.
  - Peak throughput is 1 word per 2 cycles.
- OUT_SELECT and OUT_DATA hold their last values in IDLE; the demux output is qualified only by OUT_VALID.
- A tagged item (IN_RR=0) does not change rr_ptr.
- IN_DEST and IN_RR are sampled only at the IN handshake.

Test Plan:
- Tagged dispatch: reset, then IN_DATA=0xA, IN_DEST=2, IN_RR=0, OUT_READY=4'b0100 held. Next cycle OUT_VALID=4'b0100, OUT_SELECT=2, OUT_DATA=0xA. Following cycle IN_READY=1, BUSY=0.
- Round-robin wrap: 5 words with IN_RR=1 and OUT_READY=4'hF. Each IN handshake is followed 1 cycle later by an OUT_VALID cycle; across the 5 handshakes OUT_SELECT goes 0,1,2,3,0 and OUT_VALID goes 0001,0010,0100,1000,0001. One word every 2 cycles.
- Stall then accept: IN_DEST=1, OUT_READY=0 for 5 cycles, then bit1=1. OUT_VALID=4'b0010 and OUT_DATA are stable throughout; no TIMEOUT_ERR; IN_READY=0 until the cycle after acceptance. Wrong-bit ready (4'b1101) during the stall does not complete the item.
- Timeout: TIMEOUT=15, IN_DEST=3, OUT_READY=0 forever. TIMEOUT_ERR pulses exactly once, 16 cycles after the IN handshake (15 stall cycles counted); DROP_COUNT=1; back in IDLE. Same scenario with IN_RR=1 and rr_ptr=3: rr_ptr becomes 0 after the drop.
- Ready coincident with timeout: OUT_READY asserted in the 15th stall cycle. Delivered, TIMEOUT_ERR=0, DROP_COUNT unchanged.
- Async reset mid-SEND: assert RST_N low between clock edges. All outputs are at reset values immediately, with no TIMEOUT_ERR. After release, the first word goes to dest 0 when IN_RR=1.
